// File: rtl/sdr_pkg.sv
// sdr_pkg: FSM state encodings, SDRAM command encodings {nRAS,nCAS,nWE} and address widths.
package sdr_pkg;
  localparam int BA_W = 2;
  localparam int A_W = 13;
  localparam int COL_W = 9;
  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_REF = 3'd2;
  localparam logic [2:0] S_WR = 3'd3;
  localparam logic [2:0] S_RD = 3'd4;
  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_ACTIVE = 3'b011;
  localparam logic [2:0] CMD_READ = 3'b101;
  localparam logic [2:0] CMD_WRITE = 3'b100;
  localparam logic [2:0] CMD_PRECHARGE = 3'b010;
  localparam logic [2:0] CMD_REFRESH = 3'b001;
endpackage

// File: rtl/sdr_ref_timer.sv
// sdr_ref_timer: tREFI interval counter, saturating pending-refresh counter and sticky overflow flag.
module sdr_ref_timer #(
  parameter int TREFI_CYC = 1300,
  parameter int REF_PEND_W = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic ref_done,
  output logic ref_pend_nz,
  output logic ref_ovf
);
  localparam int CNT_W = $clog2(TREFI_CYC);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REF_PEND_W-1:0] pend_q, pend_d;
  logic ovf_q, ovf_d, tick, sat;
  always_comb begin
    tick = en && cnt_q == CNT_W'(TREFI_CYC - 1);
    sat = &pend_q;
    cnt_d = !en ? cnt_q : tick ? '0 : cnt_q + 1'b1;
    // A tick and a ref_done in the same cycle cancel out.
    pend_d = (tick && !ref_done && !sat) ? pend_q + 1'b1 :
             (ref_done && !tick && pend_q != '0) ? pend_q - 1'b1 : pend_q;
    ovf_d = ovf_q | (tick && sat && !ref_done);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      pend_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      ovf_q <= ovf_d;
    end
  end
  assign ref_pend_nz = pend_q != '0;
  assign ref_ovf = ovf_q;
endmodule

// File: rtl/sdr_cmd_arb.sv
// sdr_cmd_arb: grants the SDRAM command pins to init/refresh/write/read engines through a registered mux.
// SDR_ARB_RR_EN: alternate write/read when both are pending; otherwise write has fixed priority over read.
module sdr_cmd_arb import sdr_pkg::*; #(
  parameter int TREFI_CYC = 1300,
  parameter int REF_PEND_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_done,
  input  logic [2:0]  init_cmd,
  input  logic [1:0]  init_ba,
  input  logic [12:0] init_a,
  input  logic [2:0]  ref_cmd,
  input  logic [1:0]  ref_ba,
  input  logic [12:0] ref_a,
  input  logic [2:0]  wr_cmd,
  input  logic [1:0]  wr_ba,
  input  logic [12:0] wr_a,
  input  logic [2:0]  rd_cmd,
  input  logic [1:0]  rd_ba,
  input  logic [12:0] rd_a,
  output logic        ref_start,
  input  logic        ref_done,
  output logic        wr_start,
  input  logic        wr_done,
  output logic        rd_start,
  input  logic        rd_done,
  input  logic        user_wr_req,
  output logic        user_wr_ack,
  input  logic        user_rd_req,
  output logic        user_rd_ack,
  output logic        busy,
  output logic        ref_ovf,
  output logic [1:0]  sdr_BA,
  output logic [12:0] sdr_A,
  output logic        sdr_nRAS,
  output logic        sdr_nCAS,
  output logic        sdr_nWE
);
  logic [2:0] state_q, state_d, cmd_q, cmd_d;
  logic [BA_W-1:0] ba_q, ba_d;
  logic [A_W-1:0] a_q, a_d;
  logic ref_start_q, ref_start_d, wr_start_q, wr_start_d, rd_start_q, rd_start_d;
  logic ref_pend_nz, wr_pick;
  sdr_ref_timer #(.TREFI_CYC(TREFI_CYC), .REF_PEND_W(REF_PEND_W)) u_tmr (
    .clk(clk),
    .rst_n(rst_n),
    .en(state_q != S_INIT),
    .ref_done(ref_done),
    .ref_pend_nz(ref_pend_nz),
    .ref_ovf(ref_ovf)
  );
`ifdef SDR_ARB_RR_EN
  logic last_wr_q, last_wr_d;
  assign wr_pick = user_wr_req && (!user_rd_req || !last_wr_q);
  always_comb last_wr_d = wr_start_d ? 1'b1 : rd_start_d ? 1'b0 : last_wr_q;
  always_ff @(posedge clk) last_wr_q <= !rst_n ? 1'b0 : last_wr_d;
`else
  assign wr_pick = user_wr_req;
`endif
  always_comb begin
    ref_start_d = 1'b0;
    wr_start_d = 1'b0;
    rd_start_d = 1'b0;
    state_d = state_q;
    if (state_q == S_INIT) state_d = init_done ? S_IDLE : S_INIT;
    else if (state_q == S_IDLE) begin
      ref_start_d = ref_pend_nz;
      wr_start_d = !ref_pend_nz && wr_pick;
      rd_start_d = !ref_pend_nz && !wr_pick && user_rd_req;
      state_d = ref_start_d ? S_REF : wr_start_d ? S_WR : rd_start_d ? S_RD : S_IDLE;
    end
    else if ((state_q == S_REF && ref_done) || (state_q == S_WR && wr_done) ||
             (state_q == S_RD && rd_done)) state_d = S_IDLE;
    cmd_d = state_q == S_INIT ? init_cmd : state_q == S_REF ? ref_cmd :
            state_q == S_WR ? wr_cmd : state_q == S_RD ? rd_cmd : CMD_NOP;
    ba_d = state_q == S_INIT ? init_ba : state_q == S_REF ? ref_ba :
           state_q == S_WR ? wr_ba : state_q == S_RD ? rd_ba : '0;
    a_d = state_q == S_INIT ? init_a : state_q == S_REF ? ref_a :
          state_q == S_WR ? wr_a : state_q == S_RD ? rd_a : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cmd_q <= CMD_NOP;
      ba_q <= '0;
      a_q <= '0;
      ref_start_q <= 1'b0;
      wr_start_q <= 1'b0;
      rd_start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      ba_q <= ba_d;
      a_q <= a_d;
      ref_start_q <= ref_start_d;
      wr_start_q <= wr_start_d;
      rd_start_q <= rd_start_d;
    end
  end
  assign ref_start = ref_start_q;
  assign wr_start = wr_start_q;
  assign rd_start = rd_start_q;
  assign user_wr_ack = wr_start_q;
  assign user_rd_ack = rd_start_q;
  assign busy = state_q != S_IDLE;
  assign {sdr_nRAS, sdr_nCAS, sdr_nWE} = cmd_q;
  assign sdr_BA = ba_q;
  assign sdr_A = a_q;
endmodule

// File: tb/tb_sdr_cmd_arb.sv
// tb_sdr_cmd_arb: directed checks of reset, grants, pin timing, refresh queueing and overflow.
module tb_sdr_cmd_arb;
  import sdr_pkg::*;
  logic clk = 1'b0;
  logic rst_n, init_done, ref_done, wr_done, rd_done, user_wr_req, user_rd_req;
  logic [2:0] init_cmd = CMD_PRECHARGE, ref_cmd = CMD_REFRESH, wr_cmd = CMD_WRITE, rd_cmd = CMD_READ;
  logic [1:0] init_ba = 2'd1, ref_ba = 2'd2, wr_ba = 2'd3, rd_ba = 2'd2;
  logic [12:0] init_a = 13'h0400, ref_a = 13'h1111, wr_a = 13'h0abc, rd_a = 13'h1234;
  logic ref_start, wr_start, rd_start, user_wr_ack, user_rd_ack, busy, ref_ovf;
  logic sdr_nRAS, sdr_nCAS, sdr_nWE;
  logic [1:0] sdr_BA;
  logic [12:0] sdr_A;
  logic [17:0] pins;
  int n_run = 0, n_fail = 0;
  logic ok;
  assign pins = {sdr_nRAS, sdr_nCAS, sdr_nWE, sdr_BA, sdr_A};
  always #5 clk = ~clk;
  sdr_cmd_arb #(.TREFI_CYC(16), .REF_PEND_W(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .init_cmd(init_cmd), .init_ba(init_ba), .init_a(init_a),
    .ref_cmd(ref_cmd), .ref_ba(ref_ba), .ref_a(ref_a),
    .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_a(wr_a),
    .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_a(rd_a),
    .ref_start(ref_start), .ref_done(ref_done),
    .wr_start(wr_start), .wr_done(wr_done),
    .rd_start(rd_start), .rd_done(rd_done),
    .user_wr_req(user_wr_req), .user_wr_ack(user_wr_ack),
    .user_rd_req(user_rd_req), .user_rd_ack(user_rd_ack),
    .busy(busy), .ref_ovf(ref_ovf),
    .sdr_BA(sdr_BA), .sdr_A(sdr_A),
    .sdr_nRAS(sdr_nRAS), .sdr_nCAS(sdr_nCAS), .sdr_nWE(sdr_nWE)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_init();
    rst_n = 1'b0;
    init_done = 1'b0;
    step();
    rst_n = 1'b1;
    init_done = 1'b1;
    step();
  endtask
  initial begin
    rst_n = 1'b0;
    {init_done, ref_done, wr_done, rd_done, user_wr_req, user_rd_req} = '0;
    step();
    chk("rst_pins", pins, {CMD_NOP, 15'd0});
    chk("rst_busy", busy, 1);
    chk("rst_pulses", {ref_start, wr_start, rd_start, user_wr_ack, user_rd_ack, ref_ovf}, 0);
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      ok &= pins === {init_cmd, init_ba, init_a} && !ref_start && busy;
    end
    chk("init_follow", ok, 1);
    init_done = 1'b1;
    user_rd_req = 1'b1;
    step();
    chk("idle_state", u_dut.state_q, S_IDLE);
    chk("idle_busy", busy, 0);
    step();
    chk("rd_grant", {rd_start, user_rd_ack, wr_start, ref_start}, 4'b1100);
    chk("rd_pins_late", pins, {CMD_NOP, 15'd0});
    user_rd_req = 1'b0;
    step();
    chk("rd_pins", pins, {rd_cmd, rd_ba, rd_a});
    chk("rd_pulse_end", {rd_start, user_rd_ack}, 0);
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    chk("rd_done_busy", busy, 0);
    step();
    chk("idle_nop", pins, {CMD_NOP, 15'd0});
    do_init();
    user_wr_req = 1'b1;
    user_rd_req = 1'b1;
    step();
    chk("both_r1", {wr_start, user_wr_ack, rd_start}, 3'b110);
    user_wr_req = 1'b0;
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    chk("foreign_done", u_dut.state_q, S_WR);
    chk("wr_pins", pins, {wr_cmd, wr_ba, wr_a});
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    user_wr_req = 1'b1;
    step();
`ifdef SDR_ARB_RR_EN
    chk("both_r2", {wr_start, rd_start}, 2'b01);
`else
    chk("both_r2", {wr_start, rd_start}, 2'b10);
`endif
    user_wr_req = 1'b0;
    user_rd_req = 1'b0;
    {wr_done, rd_done} = 2'b11;
    step();
    {wr_done, rd_done} = 2'b00;
    chk("r2_back_idle", u_dut.state_q, S_IDLE);
    do_init();
    user_rd_req = 1'b1;
    step();
    chk("hold_grant", rd_start, 1);
    user_rd_req = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      ok &= !ref_start && busy;
    end
    chk("hold_no_preempt", ok, 1);
    chk("hold_pend2", u_dut.u_tmr.pend_q, 2);
    rd_done = 1'b1;
    user_wr_req = 1'b1;
    step();
    rd_done = 1'b0;
    step();
    chk("ref1_first", {ref_start, user_wr_ack}, 2'b10);
    ref_done = 1'b1;
    step();
    ref_done = 1'b0;
    chk("ref1_pend", u_dut.u_tmr.pend_q, 1);
    step();
    chk("ref2_first", {ref_start, user_wr_ack}, 2'b10);
    ref_done = 1'b1;
    step();
    ref_done = 1'b0;
    step();
    chk("wr_after_ref", {ref_start, user_wr_ack}, 2'b01);
    user_wr_req = 1'b0;
    do_init();
    repeat (112) step();
    chk("sat_pend", u_dut.u_tmr.pend_q, 7);
    chk("sat_no_ovf", ref_ovf, 0);
    repeat (16) step();
    chk("ovf_set", ref_ovf, 1);
    chk("ovf_pend", u_dut.u_tmr.pend_q, 7);
    ref_done = 1'b1;
    step();
    ref_done = 1'b0;
    chk("dec_pend", u_dut.u_tmr.pend_q, 6);
    repeat (14) step();
    ref_done = 1'b1;
    step();
    ref_done = 1'b0;
    chk("tick_and_done", u_dut.u_tmr.pend_q, 6);
    chk("ovf_sticky", ref_ovf, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_clr", {ref_ovf, u_dut.u_tmr.pend_q}, 0);
    init_done = 1'b1;
    step();
    user_wr_req = 1'b1;
    step();
    user_wr_req = 1'b0;
    repeat (19) step();
    chk("midwr_pend", u_dut.u_tmr.pend_q, 1);
    chk("midwr_pins", pins, {wr_cmd, wr_ba, wr_a});
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    init_done = 1'b0;
    chk("midrst_state", u_dut.state_q, S_INIT);
    chk("midrst_pins", pins, {CMD_NOP, 15'd0});
    chk("midrst_pend", {ref_ovf, u_dut.u_tmr.pend_q}, 0);
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    chk("late_wr_done", u_dut.state_q, S_INIT);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
